// File: rtl/audio_pkg.sv
// Shared types for the note sequencer: FSM states, event field widths and the
// packed word stored in the event FIFO.
package audio_pkg;

  localparam int NOTE_W = 7;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    REST = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  gate_len;
    logic [LEN_W-1:0]  rest_len;
  } event_t;

endpackage

// File: rtl/note_event_fifo.sv
// Event queue with a registered head-of-queue word; a push into an empty queue
// becomes visible to the reader one cycle later.
module note_event_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   sample_clock,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  event_t                 din,
  output event_t                 dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LVW'(DEPTH);

  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;
  logic [AW:0]     remain;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign remain  = level - LVW'(do_pop);

  always_ff @(posedge sample_clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVW'(do_push) - LVW'(do_pop);
      // Head word tracks whichever entry will be at the front after this edge.
      if (remain == '0) begin
        if (do_push) dout <= din;
      end else if (do_pop) begin
        dout <= mem[rd_ptr + AW'(1)];
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note events as note/gate pairs for one voice; timing counts
// ticks of a programmable sample-clock prescaler.
module note_sequencer
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = LEN_W
) (
  input  logic                   sample_clock,
  input  logic                   rst,
  input  logic [15:0]            tick_div,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic [NOTE_W-1:0]      ev_note,
  input  logic [LW-1:0]          ev_gate_len,
  input  logic [LW-1:0]          ev_rest_len,
  output logic [NOTE_W-1:0]      note,
  output logic                   gate,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun
);

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     rest_q, rest_d;
  logic [15:0]       pcnt_q, pcnt_d;
  logic [NOTE_W-1:0] note_d;
  logic              gate_d;
  logic              underrun_d;
  logic [15:0]       div_eff;
  logic              tick;
  logic              pop;
  logic              start;
  logic              full;
  logic              empty;
  event_t            din;
  event_t            head;

  assign din      = '{note: ev_note, gate_len: ev_gate_len, rest_len: ev_rest_len};
  assign ev_ready = ~full & ~flush;

  note_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sample_clock (sample_clock),
    .rst          (rst),
    .flush        (flush),
    .push         (ev_valid),
    .pop          (pop),
    .din          (din),
    .dout         (head),
    .level        (level),
    .full         (full),
    .empty        (empty)
  );

  // The >= compare lets a lowered divisor take effect without losing a tick.
  always_comb begin
    div_eff = (tick_div == 16'd0) ? 16'd1 : tick_div;
    tick    = (pcnt_q >= div_eff - 16'd1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rest_d     = rest_q;
    pcnt_d     = pcnt_q;
    note_d     = note;
    gate_d     = gate;
    underrun_d = 1'b0;
    pop        = 1'b0;
    start      = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      gate_d  = 1'b0;
    end else if (enable) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      unique case (state_q)
        IDLE: start = ~empty;
        GATE: begin
          if (tick) begin
            if (cnt_q == LW'(1)) begin
              gate_d  = 1'b0;
              cnt_d   = rest_q;
              state_d = REST;
            end else begin
              cnt_d = cnt_q - LW'(1);
            end
          end
        end
        REST: begin
          // A zero rest still holds the gate low for one cycle so the voice retriggers.
          if (cnt_q == '0 || (tick && cnt_q == LW'(1))) begin
            if (!empty) begin
              start = 1'b1;
            end else begin
              state_d    = IDLE;
              underrun_d = 1'b1;
            end
          end else if (tick) begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        pop    = 1'b1;
        pcnt_d = '0;
        note_d = head.note;
        rest_d = head.rest_len;
        if (head.gate_len != '0) begin
          cnt_d   = head.gate_len;
          gate_d  = 1'b1;
          state_d = GATE;
        end else begin
          cnt_d   = head.rest_len;
          gate_d  = 1'b0;
          state_d = REST;
        end
      end
    end
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rest_q   <= '0;
      pcnt_q   <= '0;
      note     <= '0;
      gate     <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rest_q   <= rest_d;
      pcnt_q   <= pcnt_d;
      note     <= note_d;
      gate     <= gate_d;
      busy     <= (state_d != IDLE);
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random traffic, compared each
// cycle against an event/duration model of the sequencer.
module tb_note_sequencer;

  localparam int DEPTH = 16;
  localparam int LW    = 8;

  logic          sample_clock = 1'b0;
  logic          rst;
  logic [15:0]   tick_div;
  logic          enable;
  logic          flush;
  logic          ev_valid;
  logic          ev_ready;
  logic [6:0]    ev_note;
  logic [LW-1:0] ev_gate_len;
  logic [LW-1:0] ev_rest_len;
  logic [6:0]    note;
  logic          gate;
  logic          busy;
  logic [4:0]    level;
  logic          underrun;

  always #5 sample_clock = ~sample_clock;

  note_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .sample_clock (sample_clock),
    .rst          (rst),
    .tick_div     (tick_div),
    .enable       (enable),
    .flush        (flush),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note      (ev_note),
    .ev_gate_len  (ev_gate_len),
    .ev_rest_len  (ev_rest_len),
    .note         (note),
    .gate         (gate),
    .busy         (busy),
    .level        (level),
    .underrun     (underrun)
  );

  typedef struct {
    int note;
    int g;
    int r;
  } ev_s;

  int  n_checks = 0;
  int  n_fails  = 0;
  ev_s q[$];
  int  m_phase;   // 0 idle, 1 gate high, 2 gate low
  int  m_rem;     // cycles left in the current phase
  int  m_note, m_gate, m_under, cur_r;
  int  hi_cnt, busy_cnt, un_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = 0; m_rem = 0; m_note = 0; m_gate = 0; m_under = 0; cur_r = 0;
  endtask

  function automatic int low_time(input int r, input int d);
    return (r * d > 0) ? r * d : 1;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT is about to see.
  task automatic model_edge();
    int  d;
    bit  pushing, start;
    ev_s e, h;
    d = (tick_div == 16'd0) ? 1 : int'(tick_div);
    pushing = ev_valid && (q.size() < DEPTH) && !flush;
    e = '{int'(ev_note), int'(ev_gate_len), int'(ev_rest_len)};
    m_under = 0;
    start = 0;
    if (flush) begin
      q.delete();
      m_phase = 0; m_gate = 0; m_rem = 0;
      return;
    end
    if (enable) begin
      case (m_phase)
        0: start = (q.size() > 0);
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2; m_gate = 0; m_rem = low_time(cur_r, d);
          end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) begin
            if (q.size() > 0) start = 1;
            else begin m_phase = 0; m_under = 1; end
          end
        end
      endcase
      if (start) begin
        h = q.pop_front();
        m_note = h.note;
        cur_r  = h.r;
        if (h.g > 0) begin
          m_phase = 1; m_gate = 1; m_rem = h.g * d;
        end else begin
          m_phase = 2; m_gate = 0; m_rem = low_time(h.r, d);
        end
      end
    end
    if (pushing) q.push_back(e);
  endtask

  task automatic check_all();
    check("gate", gate, m_gate);
    check("note", note, m_note);
    check("busy", busy, m_phase != 0);
    check("level", level, q.size());
    check("underrun", underrun, m_under);
    check("ev_ready", ev_ready, (q.size() < DEPTH) && !flush);
    hi_cnt   += int'(gate);
    busy_cnt += int'(busy);
    un_cnt   += int'(underrun);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge sample_clock);
    #1;
    check_all();
  endtask

  task automatic set_ev(input int n, input int g, input int r);
    ev_note = 7'(n); ev_gate_len = LW'(g); ev_rest_len = LW'(r);
  endtask

  task automatic clr_cnt();
    hi_cnt = 0; busy_cnt = 0; un_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; tick_div = 16'd1; enable = 1'b1; flush = 1'b0; ev_valid = 1'b0;
    set_ev(0, 0, 0);
    model_reset();
    clr_cnt();
    #12;
    check("rst_note", note, 0);
    check("rst_gate", gate, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_underrun", underrun, 0);
    @(posedge sample_clock); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", ev_ready, 1);

    // Single event, divisor 4
    tick_div = 16'd4;
    clr_cnt();
    ev_valid = 1'b1; set_ev(60, 2, 1);
    cyc();
    ev_valid = 1'b0;
    check("t1_gate_after_push", gate, 0);
    cyc();
    check("t1_gate_rise", gate, 1);
    check("t1_note", note, 60);
    for (int i = 0; i < 18; i++) cyc();
    check("t1_high", hi_cnt, 8);
    check("t1_low", busy_cnt - hi_cnt, 4);
    check("t1_underrun", un_cnt, 1);

    // Three back-to-back events, divisor 2
    tick_div = 16'd2;
    clr_cnt();
    ev_valid = 1'b1;
    set_ev(60, 1, 0); cyc();
    set_ev(64, 1, 0); cyc();
    set_ev(67, 1, 0); cyc();
    ev_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    check("t2_high", hi_cnt, 6);
    check("t2_busy", busy_cnt, 9);
    check("t2_underrun", un_cnt, 1);
    check("t2_last_note", note, 67);

    // Fill the queue while frozen, then drain
    tick_div = 16'd1;
    enable = 1'b0;
    clr_cnt();
    ev_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_ev(40 + i, 1, 0);
      cyc();
    end
    check("t3_full_ready", ev_ready, 0);
    check("t3_full_level", level, 16);
    set_ev(99, 1, 0);
    cyc();
    check("t3_17th_level", level, 16);
    ev_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    check("t3_drained", level, 0);
    check("t3_underrun", un_cnt, 1);

    // Zero gate length
    clr_cnt();
    ev_valid = 1'b1; set_ev(50, 0, 3);
    cyc();
    ev_valid = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    check("t4_high", hi_cnt, 0);
    check("t4_busy", busy_cnt, 3);
    check("t4_note", note, 50);

    // Flush mid-gate with five queued
    tick_div = 16'd2;
    ev_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ev(70 + i, 3, 2);
      cyc();
    end
    check("t5_level_before", level, 5);
    check("t5_gate_before", gate, 1);
    flush = 1'b1; set_ev(90, 1, 1);
    #1;
    check("t5_ready_in_flush", ev_ready, 0);
    cyc();
    flush = 1'b0; ev_valid = 1'b0;
    check("t5_gate", gate, 0);
    check("t5_level", level, 0);
    check("t5_busy", busy, 0);
    check("t5_note", note, 70);
    cyc();
    check("t5_level_after", level, 0);

    // Enable pause mid-gate, then async reset during rest
    tick_div = 16'd3;
    clr_cnt();
    ev_valid = 1'b1; set_ev(55, 4, 2);
    cyc();
    ev_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (!gate) break;
    end
    check("t6_high", hi_cnt, 22);
    cyc(); cyc();
    check("t6_in_rest", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_gate", gate, 0);
    check("t6_rst_note", note, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_underrun", underrun, 0);
    model_reset();
    @(posedge sample_clock); #1;
    rst = 1'b0;

    // Random traffic segments, each drained before the divisor changes
    for (int s = 0; s < 6; s++) begin
      tick_div = 16'($urandom_range(0, 3));
      for (int i = 0; i < 150; i++) begin
        ev_valid = ($urandom_range(0, 2) == 0);
        set_ev($urandom_range(0, 127), $urandom_range(0, 3), $urandom_range(0, 3));
        enable = ($urandom_range(0, 7) != 0);
        flush  = ($urandom_range(0, 63) == 0);
        cyc();
      end
      ev_valid = 1'b0; enable = 1'b1; flush = 1'b0;
      for (int i = 0; i < 320; i++) cyc();
      check("rand_drained_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Event-driven note/gate generator that sits directly upstream of one synth voice, running on the audio sample clock. A bus bridge pushes note events (note number, gate length, rest length) into a small FIFO, and the sequencer plays them back in order. Its `note` and `gate` outputs drive a voice's `note` and `gate` inputs. Timing is in ticks, and one tick is a programmable number of sample clocks.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `LW`, 8: width of gate/rest length fields, in ticks.

- `sample_clock`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `tick_div`  in  16: sample clocks per tick; 0 treated as 1.
- `enable`  in  1: 1 = run, 0 = freeze playback.
- `flush`  in  1: synchronous clear of queue and playback.
- `ev_valid`  in  1: event offered.
- `ev_ready`  out  1: event accepted when `ev_valid & ev_ready`.
- `ev_note`  in  7: MIDI note number.
- `ev_gate_len`  in  LW: ticks gate is high.
- `ev_rest_len`  in  LW: ticks gate is low afterwards.
- `note`  out  7: current note to the voice.
- `gate`  out  1: gate to the voice.
- `busy`  out  1: state ≠ IDLE.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `underrun`  out  1: one-cycle pulse, queue ran dry after an event.

## Operation
- FIFO:
  - Entry is {note, gate_len, rest_len}.
  - `ev_ready = (level < DEPTH) & ~flush`.
  - No fall-through: a push is visible to the FSM one cycle later.
  - A push and a pop in the same cycle leave `level` unchanged.
- Prescaler:
  - `pcnt` counts sample clocks and emits `tick` when `pcnt >= D-1`, then wraps to 0. D = max(tick_div,1).
  - `pcnt` is cleared on every pop.
  - Because the compare is `>=`, a lowered `tick_div` takes effect on the next cycle without a lost tick.
- FSM states: IDLE, GATE, REST.
  - IDLE: if `enable` and FIFO non-empty, pop and latch `note`.
    - gate_len > 0: load `cnt = gate_len`, `gate` ← 1, go to GATE.
    - gate_len = 0: go straight to REST with `gate` at 0.
  - GATE: on `tick`, decrement `cnt`. When `cnt` would reach 0: `gate` ← 0, load `cnt = rest_len`, go to REST.
  - REST: on `tick`, decrement `cnt`. The state ends when `cnt` would reach 0, or after exactly 1 cycle if rest_len = 0 (minimum low gate of one cycle, so the envelope always retriggers).
    - At REST end with FIFO non-empty: pop in that same cycle and apply the IDLE pop rules. There is no IDLE bubble.
    - At REST end with FIFO empty: go to IDLE and pulse `underrun`.
- `enable` = 0:
  - `pcnt` and `cnt` hold, no pops occur, outputs hold.
  - The FIFO still accepts pushes.
- `flush` has priority over everything else:
  - Next cycle: FIFO empty, state IDLE, `gate` 0, `pcnt`/`cnt` 0.
  - `note` keeps its last value.
  - Any push offered in the flush cycle is dropped (`ev_ready` is 0).
- Reset values: `note` 0, `gate` 0, `busy` 0, `level` 0, `underrun` 0, state IDLE. `ev_ready` is 1 once reset is released.

## Timing
- All outputs are registered except `ev_ready`, which is combinational from `level` and `flush`.
- Latency:
  - Push accepted on edge k into an empty, idle, enabled sequencer → `level` = 1 after edge k.
  - Pop on edge k+1; `note` and `gate` = 1 valid after edge k+1.
- Durations, with D = effective divisor:
  - `gate` is high for exactly gate_len·D cycles.
  - `gate` is low for max(rest_len·D, 1) cycles.
  - Back-to-back events repeat with a period of (g+r)·D cycles (r ≥ 1).
- `underrun` is high for the single cycle after REST completes with the queue empty.
- Asserting `rst` mid-event drops `gate` immediately (asynchronously) and discards the queue.

## Structure
- Shared package `audio_pkg`:
  - FSM state enum (IDLE, GATE, REST).
  - Event-field width constants (note 7, length LW).
  - Packed event-word layout.
- Sub-module `note_event_fifo`:
  - Synchronous FIFO with registered read data.
  - Ports: push, pop, din, dout, level, full, empty, flush.
  - Same clock/reset as the parent.
- The FSM, prescaler and output registers live in the top module.

## Test plan
- Reset, then `tick_div`=4, push {60,2,1} → `gate` rises 2 cycles after the push, stays high 8 cycles, low 4 cycles; `underrun` pulses once; `note`=60 throughout.
- Push 3 events {60,1,0},{64,1,0},{67,1,0} with `tick_div`=2:
  - Gate pattern is high 2 / low 1, three times.
  - `note` steps 60→64→67 on each rising gate.
  - `busy` stays 1 until the final IDLE.
- Fill FIFO with 16 events while `enable`=0 → `ev_ready`=0 and `level`=16; a 17th `ev_valid` is not accepted; raise `enable` → `level` decrements once per event.
- Event {50,0,3} with `tick_div`=1 → `gate` never rises, `note`=50 after the pop, `busy` for 3 cycles.
- Assert `flush` mid-GATE with 5 events queued → next cycle `gate`=0, `level`=0, `busy`=0, `note` unchanged; a push in the flush cycle is ignored.
- Drop `enable` for 10 cycles mid-GATE (`tick_div`=3, gate_len 4) → total gate-high time is 12+10 = 22 cycles; assert `rst` during REST → all outputs at reset values asynchronously.
